// File: rtl/chip8_pkg.sv
// Shared CHIP-8 display constants, draw FSM state encoding and display addressing helper.
// Contents:
//   DISP_W, DISP_H, DISP_BYTES_PER_ROW  display geometry (1 bpp, 8 pixels per byte)
//   draw_state_t                        sprite draw engine state encoding
//   disp_byte_addr(row, col_byte)       packs a display byte address {row, col_byte}
package chip8_pkg;

  localparam int unsigned DISP_W             = 64;
  localparam int unsigned DISP_H             = 32;
  localparam int unsigned DISP_BYTES_PER_ROW = DISP_W / 8;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    FETCH = 4'd1,
    CAPT  = 4'd2,
    RD_L  = 4'd3,
    WR_L  = 4'd4,
    RD_R  = 4'd5,
    WR_R  = 4'd6,
    NEXT  = 4'd7,
    DONE  = 4'd8
  } draw_state_t;

  function automatic logic [7:0] disp_byte_addr(input logic [4:0] row,
                                                input logic [2:0] col_byte);
    return {row, col_byte};
  endfunction

endpackage

// File: rtl/sprite_draw_engine_if.sv
// Bundles the CPU command/status, main-memory read port and display RAM port of the
// sprite draw engine.
// Modports:
//   master  engine side: takes start/x/y/n/sprite_addr, mem_q, disp_q;
//           drives busy/done/collision, mem_addr/mem_re, disp_addr/disp_we/disp_d
//   slave   system side (CPU, main memory, display RAM): the mirror image
interface sprite_draw_engine_if #(
  parameter int unsigned MEM_AW = 12
);
  logic              start;
  logic [7:0]        x;
  logic [7:0]        y;
  logic [3:0]        n;
  logic [MEM_AW-1:0] sprite_addr;
  logic              busy;
  logic              done;
  logic              collision;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_re;
  logic [7:0]        mem_q;
  logic [7:0]        disp_addr;
  logic              disp_we;
  logic [7:0]        disp_d;
  logic [7:0]        disp_q;

  modport master (
    input  start, x, y, n, sprite_addr, mem_q, disp_q,
    output busy, done, collision, mem_addr, mem_re, disp_addr, disp_we, disp_d
  );

  modport slave (
    output start, x, y, n, sprite_addr, mem_q, disp_q,
    input  busy, done, collision, mem_addr, mem_re, disp_addr, disp_we, disp_d
  );

endinterface

// File: rtl/sprite_align.sv
// Splits one sprite byte across two display bytes for a pixel offset within a byte.
// Ports:
//   data   in  8  sprite byte, bit 7 is the leftmost pixel
//   shift  in  3  pixel offset inside the display byte (x[2:0])
//   left   out 8  bits landing in the display byte containing pixel x
//   right  out 8  bits spilling into the next display byte (zero when shift==0)
module sprite_align (
  input  logic [7:0] data,
  input  logic [2:0] shift,
  output logic [7:0] left,
  output logic [7:0] right
);

  logic [15:0] sh;

  assign sh    = {data, 8'h00} >> shift;
  assign left  = sh[15:8];
  assign right = sh[7:0];

endmodule

// File: rtl/sprite_draw_engine.sv
// CHIP-8 DXYN sprite draw: fetches n sprite bytes from main memory and XORs them into the
// 64x32 1-bpp display RAM via a single read/write port, wrapping in both axes.
// Ports:
//   clk    in  system clock
//   rst_n  in  synchronous active-low reset
//   bus    sprite_draw_engine_if.master
//          CPU side:     start, x, y, n, sprite_addr -> busy, done, collision
//          main memory:  mem_addr, mem_re -> mem_q (one-cycle read latency)
//          display RAM:  disp_addr, disp_we, disp_d -> disp_q (one-cycle read latency)
module sprite_draw_engine #(
  parameter int unsigned MEM_AW             = 12,
  parameter int unsigned DISP_BYTES_PER_ROW = 8,
  parameter int unsigned DISP_ROWS          = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sprite_draw_engine_if.master bus
);

  import chip8_pkg::*;

  localparam int unsigned COL_W = $clog2(DISP_BYTES_PER_ROW);
  localparam int unsigned ROW_W = $clog2(DISP_ROWS);

  draw_state_t       state_q, state_d;
  logic [COL_W+2:0]  x_q;
  logic [ROW_W-1:0]  y_q;
  logic [3:0]        n_q;
  logic [3:0]        i_q;
  logic [MEM_AW-1:0] addr_q;
  logic [7:0]        left_q, right_q;
  logic              coll_q;

  logic [7:0]        al_left, al_right;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col_l, col_r;
  logic [7:0]        addr_l, addr_r;
  logic              aligned;

  // Only the low bits of x/y matter: coordinates wrap modulo the display size.
  logic unused_coord;
  assign unused_coord = ^{bus.x[7:COL_W+3], bus.y[7:ROW_W]};

  sprite_align u_align (
    .data  (bus.mem_q),
    .shift (x_q[2:0]),
    .left  (al_left),
    .right (al_right)
  );

  assign aligned = (x_q[2:0] == 3'd0);
  assign row     = y_q + ROW_W'(i_q);
  assign col_l   = x_q[COL_W+2:3];
  assign col_r   = col_l + COL_W'(1);
  assign addr_l  = disp_byte_addr(row, col_l);
  assign addr_r  = disp_byte_addr(row, col_r);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = (bus.n == 4'd0) ? DONE : FETCH;
      FETCH:   state_d = CAPT;
      CAPT:    state_d = RD_L;
      RD_L:    state_d = WR_L;
      WR_L:    state_d = aligned ? NEXT : RD_R;
      RD_R:    state_d = WR_R;
      WR_R:    state_d = NEXT;
      NEXT:    state_d = (4'(i_q + 4'd1) == n_q) ? DONE : FETCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      n_q     <= '0;
      i_q     <= '0;
      addr_q  <= '0;
      left_q  <= '0;
      right_q <= '0;
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            x_q    <= bus.x[COL_W+2:0];
            y_q    <= bus.y[ROW_W-1:0];
            n_q    <= bus.n;
            addr_q <= bus.sprite_addr;
            i_q    <= '0;
            coll_q <= 1'b0;
          end
        end
        CAPT: begin
          left_q  <= al_left;
          right_q <= al_right;
        end
        WR_L:    coll_q <= coll_q | (|(bus.disp_q & left_q));
        WR_R:    coll_q <= coll_q | (|(bus.disp_q & right_q));
        NEXT:    i_q    <= i_q + 4'd1;
        default: ;
      endcase
    end
  end

  // Outputs decode from the registered state. disp_we is also qualified by rst_n so a
  // reset asserted during a write cycle cannot let that write land in the display RAM.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_re    = 1'b0;
    bus.disp_addr = '0;
    bus.disp_we   = 1'b0;
    bus.disp_d    = '0;
    unique case (state_q)
      FETCH: begin
        bus.mem_addr = addr_q + MEM_AW'(i_q);
        bus.mem_re   = 1'b1;
      end
      RD_L: bus.disp_addr = addr_l;
      WR_L: begin
        bus.disp_addr = addr_l;
        bus.disp_we   = rst_n;
        bus.disp_d    = bus.disp_q ^ left_q;
      end
      RD_R: bus.disp_addr = addr_r;
      WR_R: begin
        bus.disp_addr = addr_r;
        bus.disp_we   = rst_n;
        bus.disp_d    = bus.disp_q ^ right_q;
      end
      default: ;
    endcase
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.collision = coll_q;

endmodule

// File: tb/tb_sprite_draw_engine.sv
// Bench for sprite_draw_engine: behavioural main memory and display RAM, a write scoreboard
// filled by each scenario and drained by a display-port monitor.
module tb_sprite_draw_engine;

  localparam int unsigned MEM_AW = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sprite_draw_engine_if #(.MEM_AW(MEM_AW)) bus ();

  sprite_draw_engine #(
    .MEM_AW             (MEM_AW),
    .DISP_BYTES_PER_ROW (8),
    .DISP_ROWS          (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0]  mem  [0:4095];
  logic [7:0]  disp [0:255];
  logic [15:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int mem_re_cnt = 0;
  int wr_cnt = 0;

  // Memory models: one-cycle read latency, display read-before-write.
  always @(posedge clk) begin
    if (bus.mem_re) bus.mem_q <= mem[bus.mem_addr];
    if (bus.disp_we) disp[bus.disp_addr] <= bus.disp_d;
    bus.disp_q <= disp[bus.disp_addr];
  end

  // Display-port monitor: every write must match the next expected {addr, data}.
  always @(negedge clk) begin
    logic [15:0] e;
    if (bus.mem_re) mem_re_cnt++;
    if (bus.disp_we) begin
      wr_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL disp_write unexpected: got addr %h data %h, required no write",
                 bus.disp_addr, bus.disp_d);
      end else begin
        e = exp_q.pop_front();
        if ({bus.disp_addr, bus.disp_d} !== e) begin
          errors++;
          $display("FAIL disp_write: got addr %h data %h, required addr %h data %h",
                   bus.disp_addr, bus.disp_d, e[15:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_disp();
    for (int i = 0; i < 256; i++) disp[i] = 8'h00;
  endtask

  // Issues one start and counts busy cycles up to and including the done cycle.
  task automatic do_draw(input logic [7:0] dx, input logic [7:0] dy, input logic [3:0] dn,
                         input logic [11:0] da, output int cyc, output logic coll,
                         output bit got);
    @(negedge clk);
    bus.x = dx; bus.y = dy; bus.n = dn; bus.sprite_addr = da; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    cyc = 0; coll = 1'bx; got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) cyc++;
      if (bus.done === 1'b1) begin
        got = 1'b1;
        coll = bus.collision;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 8;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", bus.done); end
    if (bus.collision !== 1'b0) begin
      errors++; $display("FAIL reset_collision: got %b, required 0", bus.collision);
    end
    if (bus.mem_re !== 1'b0) begin errors++; $display("FAIL reset_mem_re: got %b, required 0", bus.mem_re); end
    if (bus.disp_we !== 1'b0) begin
      errors++; $display("FAIL reset_disp_we: got %b, required 0", bus.disp_we);
    end
    if (bus.mem_addr !== 12'h000) begin
      errors++; $display("FAIL reset_mem_addr: got %h, required 000", bus.mem_addr);
    end
    if (bus.disp_addr !== 8'h00) begin
      errors++; $display("FAIL reset_disp_addr: got %h, required 00", bus.disp_addr);
    end
    if (bus.disp_d !== 8'h00) begin errors++; $display("FAIL reset_disp_d: got %h, required 00", bus.disp_d); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_aligned(input logic [7:0] exp_data, input logic exp_coll, input string nm);
    int cyc; logic coll; bit got;
    mem[12'h200] = 8'hF0;
    exp_q.push_back({8'h00, exp_data});
    mem_re_cnt = 0;
    do_draw(8'd0, 8'd0, 4'd1, 12'h200, cyc, coll, got);
    checks += 5;
    if (got !== 1'b1) begin errors++; $display("FAIL %s_done: got no done, required done", nm); end
    if (cyc !== 6) begin errors++; $display("FAIL %s_latency: got %0d, required 6", nm, cyc); end
    if (coll !== exp_coll) begin
      errors++; $display("FAIL %s_collision: got %b, required %b", nm, coll, exp_coll);
    end
    if (mem_re_cnt !== 1) begin
      errors++; $display("FAIL %s_mem_re: got %0d, required 1", nm, mem_re_cnt);
    end
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL %s_writes_left: got %0d, required 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_unaligned();
    int cyc; logic coll; bit got;
    clear_disp();
    mem[12'h210] = 8'hFF;
    exp_q.push_back(16'h101F);
    exp_q.push_back(16'h11E0);
    do_draw(8'd3, 8'd2, 4'd1, 12'h210, cyc, coll, got);
    checks += 4;
    if (got !== 1'b1) begin errors++; $display("FAIL unaligned_done: got no done, required done"); end
    if (cyc !== 8) begin errors++; $display("FAIL unaligned_latency: got %0d, required 8", cyc); end
    if (coll !== 1'b0) begin errors++; $display("FAIL unaligned_collision: got %b, required 0", coll); end
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL unaligned_writes_left: got %0d, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_wrap();
    int cyc; logic coll; bit got;
    mem[12'hFFF] = 8'hC0;
    mem[12'h000] = 8'h81;
    exp_q.push_back(16'hFF03);
    exp_q.push_back(16'hF800);
    exp_q.push_back(16'h0702);
    exp_q.push_back(16'h0004);
    mem_re_cnt = 0;
    do_draw(8'd62, 8'd31, 4'd2, 12'hFFF, cyc, coll, got);
    checks += 5;
    if (got !== 1'b1) begin errors++; $display("FAIL wrap_done: got no done, required done"); end
    if (cyc !== 15) begin errors++; $display("FAIL wrap_latency: got %0d, required 15", cyc); end
    if (coll !== 1'b0) begin errors++; $display("FAIL wrap_collision: got %b, required 0", coll); end
    if (mem_re_cnt !== 2) begin errors++; $display("FAIL wrap_mem_re: got %0d, required 2", mem_re_cnt); end
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL wrap_writes_left: got %0d, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_zero_height();
    int cyc; logic coll; bit got;
    mem_re_cnt = 0;
    wr_cnt = 0;
    do_draw(8'd5, 8'd5, 4'd0, 12'h123, cyc, coll, got);
    @(negedge clk);
    checks += 5;
    if (got !== 1'b1) begin errors++; $display("FAIL zero_done: got no done, required done"); end
    if (cyc !== 1) begin errors++; $display("FAIL zero_latency: got %0d, required 1", cyc); end
    if (mem_re_cnt !== 0) begin errors++; $display("FAIL zero_mem_re: got %0d, required 0", mem_re_cnt); end
    if (wr_cnt !== 0) begin errors++; $display("FAIL zero_writes: got %0d, required 0", wr_cnt); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL zero_idle_after: got %b, required 0", bus.busy); end
  endtask

  task automatic test_start_while_busy();
    int cyc; bit got;
    clear_disp();
    mem[12'h300] = 8'hAA;
    mem[12'h310] = 8'h55;
    exp_q.push_back(16'h29AA);
    mem_re_cnt = 0;
    @(negedge clk);
    bus.x = 8'd8; bus.y = 8'd5; bus.n = 4'd1; bus.sprite_addr = 12'h300; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    cyc = 0; got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) cyc++;
      if (bus.done === 1'b1) got = 1'b1;
      if (cyc == 2 && !got) begin
        bus.x = 8'd16; bus.y = 8'd10; bus.n = 4'd3; bus.sprite_addr = 12'h310; bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
    end
    @(negedge clk);
    checks += 6;
    if (got !== 1'b1) begin errors++; $display("FAIL busy_start_done: got no done, required done"); end
    if (cyc !== 6) begin errors++; $display("FAIL busy_start_latency: got %0d, required 6", cyc); end
    if (mem_re_cnt !== 1) begin
      errors++; $display("FAIL busy_start_mem_re: got %0d, required 1", mem_re_cnt);
    end
    if (disp[8'h29] !== 8'hAA) begin
      errors++; $display("FAIL busy_start_disp: got %h, required aa", disp[8'h29]);
    end
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL busy_start_idle_after: got %b, required 0", bus.busy);
    end
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL busy_start_writes_left: got %0d, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_write();
    int cyc; logic coll; bit got;
    clear_disp();
    disp[8'h00] = 8'h04;
    mem[12'h400] = 8'h04;
    mem[12'h401] = 8'h3C;
    exp_q.push_back(16'h0000);
    @(negedge clk);
    bus.x = 8'd0; bus.y = 8'd0; bus.n = 4'd2; bus.sprite_addr = 12'h400; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    cyc = 0;
    for (int k = 0; k < 50 && cyc < 8; k++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) cyc++;
    end
    // Next cycle is the second row's left write.
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks += 6;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b, required 0", bus.busy); end
    if (bus.disp_we !== 1'b0) begin
      errors++; $display("FAIL rst_mid_disp_we: got %b, required 0", bus.disp_we);
    end
    if (bus.collision !== 1'b0) begin
      errors++; $display("FAIL rst_mid_collision: got %b, required 0", bus.collision);
    end
    if (bus.mem_re !== 1'b0) begin errors++; $display("FAIL rst_mid_mem_re: got %b, required 0", bus.mem_re); end
    if (disp[8'h08] !== 8'h00) begin
      errors++; $display("FAIL rst_mid_partial_write: got %h, required 00", disp[8'h08]);
    end
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL rst_mid_writes_left: got %0d, required 0", exp_q.size());
      exp_q.delete();
    end
    rst_n = 1'b1;
    exp_q.push_back(16'h0004);
    exp_q.push_back(16'h083C);
    do_draw(8'd0, 8'd0, 4'd2, 12'h400, cyc, coll, got);
    checks += 4;
    if (got !== 1'b1) begin errors++; $display("FAIL rst_rerun_done: got no done, required done"); end
    if (cyc !== 11) begin errors++; $display("FAIL rst_rerun_latency: got %0d, required 11", cyc); end
    if (coll !== 1'b0) begin errors++; $display("FAIL rst_rerun_collision: got %b, required 0", coll); end
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL rst_rerun_writes_left: got %0d, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.x = '0;
    bus.y = '0;
    bus.n = '0;
    bus.sprite_addr = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    clear_disp();
    test_reset();
    clear_disp();
    test_aligned(8'hF0, 1'b0, "aligned_first");
    test_aligned(8'h00, 1'b1, "aligned_repeat");
    test_unaligned();
    test_wrap();
    test_zero_height();
    test_start_while_busy();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_draw_engine.md
Name: sprite_draw_engine

Overview:
- Executes the CHIP-8 DXYN draw.
- Fetches N sprite bytes from main memory and XORs them into the 64x32 1-bpp display RAM through one read/write port of that RAM.
- Raises a collision flag for VF.
- Sits between the CPU execute stage, which issues start and receives done/collision, and display_ram, which it drives.
- The other display_ram port stays with scanout.

Parameters:
- MEM_AW, 12, main-memory address width.
- DISP_BYTES_PER_ROW, 8, display bytes per pixel row (64 px / 8).
- DISP_ROWS, 32, display rows.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle request; accepted only when idle
- x  in  8  X coordinate; bits [5:0] used (mod 64)
- y  in  8  Y coordinate; bits [4:0] used (mod 32)
- n  in  4  sprite height in rows
- sprite_addr  in  MEM_AW  address of first sprite byte (I register)
- mem_addr  out  MEM_AW  main-memory read address
- mem_re  out  1  main-memory read strobe
- mem_q  in  8  read data, valid the cycle after mem_re
- disp_addr  out  8  display address {row[4:0], col_byte[2:0]}
- disp_we  out  1  display write enable
- disp_d  out  8  display write data
- disp_q  in  8  display read data, valid the cycle after disp_addr is presented with disp_we=0
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at completion
- collision  out  1  set if any lit pixel was cleared; valid from done until next accepted start

Behaviour:
- Reset (rst_n=0 at a clk edge, including mid-operation) forces:
  - state IDLE.
  - mem_re=0, disp_we=0, done=0, busy=0, collision=0.
  - mem_addr=0, disp_addr=0, disp_d=0.
- No partial write completes after reset.
- Pixel order: bit 7 of a display byte is the leftmost pixel. Sprite bit 7 maps to pixel x.
- Wrap, no clipping:
  - Column byte index is mod 8.
  - Row index is mod 32.
  - Sprite address increments mod 2^MEM_AW.
- Alignment, per row i (0..n-1):
  - sh = {byte, 8'h00} >> x[2:0]; left = sh[15:8], right = sh[7:0].
  - Left target is {(y+i) mod 32, x[5:3]}.
  - Right target is {(y+i) mod 32, (x[5:3]+1) mod 8}.
  - The right access is skipped entirely when x[2:0]==0.
- States and per-state outputs:
  - IDLE: if start, latch x, y, n, sprite_addr; clear collision and row counter. If n==0 go to DONE, else go to FETCH. start while busy is ignored.
  - FETCH: mem_addr = sprite_addr+i, mem_re=1. Go to CAPT.
  - CAPT: register the shifted mem_q into left/right. Go to RD_L.
  - RD_L: disp_addr = left target, disp_we=0. Go to WR_L.
  - WR_L: disp_addr = left target, disp_we=1, disp_d = disp_q ^ left; collision |= |(disp_q & left). If x[2:0]!=0 go to RD_R, else go to NEXT.
  - RD_R / WR_R: same as RD_L / WR_L using the right target.
  - NEXT: i++. If i==n go to DONE, else go to FETCH.
  - DONE: done=1 for one cycle. Go to IDLE.
- Outputs mem_re, disp_we, disp_addr and disp_d are registered or decoded from the registered state only. There is no combinational path from disp_q to disp_we.
- Latency, with start accepted at edge T (state IDLE before T):
  - Aligned: 5n+1 cycles of busy, done in the final busy cycle.
  - Unaligned: 7n+1 cycles of busy.
  - n=0: DONE in cycle T+1, with no memory or display accesses.
- Collision is sticky across rows and held after done until the next accepted start.
- Scanout on the other display_ram port is not arbitrated. A read of an address mid-update returns either the old or the new byte.

Decomposition:
- chip8_pkg holds:
  - DISP_W=64, DISP_H=32, DISP_BYTES_PER_ROW.
  - The draw_state_t enum {IDLE, FETCH, CAPT, RD_L, WR_L, RD_R, WR_R, NEXT, DONE}.
  - Function disp_byte_addr(row, col_byte).
- One combinational sub-module, sprite_align: byte and x[2:0] in, left/right out. It is reusable for the future SCHIP 16-bit sprites.

Test Plan:
- Cleared display; x=0, y=0, n=1, mem[0x200]=0xF0 -> one write, addr 0x00 data 0xF0; collision=0; done 5 cycles after start edge; exactly one mem_re.
- Repeat the same draw -> addr 0x00 data 0x00; collision=1 at done.
- Cleared display; x=3, y=2, n=1, byte 0xFF -> writes addr 0x10=0x1F then 0x11=0xE0; done after 7 cycles.
- x=62, y=31, n=2, bytes 0xC0, 0x81 at sprite_addr=0xFFF/0x000 (address wrap):
  - Row 31: addr 0xFF=0x03, addr 0xF8=0x00.
  - Row 0: addr 0x07=0x02, addr 0x00=0x04.
  - collision=0.
- n=0 -> busy one cycle, done pulse; no mem_re, no disp_we.
- start pulsed again while busy -> ignored, no latch change. rst_n=0 in WR_L cycle -> next cycle busy=0, disp_we=0, collision=0, state IDLE; a following start runs normally.
